// File: rtl/tankb_timing_pkg.sv
// Shared constants and state encodings for the Tank Battalion video timing block.
package tankb_timing_pkg;

    localparam logic [8:0] H_LOAD_DEF = 9'd128;
    localparam logic [8:0] V_LOAD_DEF = 9'd248;

    localparam int unsigned HSYNC_START = 176;
    localparam int unsigned HSYNC_END   = 208;
    localparam int unsigned VSYNC_FIRST = 248;
    localparam int unsigned H_TOTAL     = 384;
    localparam int unsigned V_TOTAL     = 264;

    // Divide-by-3 ring as the ls107 pair {q1,q2}: 00 -> 10 -> 01 -> 00
    typedef enum logic [1:0] {
        DIV_S0 = 2'b00,
        DIV_S1 = 2'b10,
        DIV_S2 = 2'b01
    } div_state_t;

endpackage

// File: rtl/ttl161_cnt.sv
// 4-bit ls161-style synchronous counter cell: clear, load (over count), enp/ent.
module ttl161_cnt (
    input  logic       clk,
    input  logic       clr,
    input  logic       ce,
    input  logic       load,
    input  logic       enp,
    input  logic       ent,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       rco
);

    // Counter register: clear wins, then load, then count on enp & ent
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (ce) begin
            if (load) begin
                q <= d;
            end else if (enp && ent) begin
                q <= q + 4'd1;
            end
        end
    end

    assign rco = ent & (q == 4'hF);

endmodule

// File: rtl/tankb_video_timing.sv
// Tank Battalion video timing generator: pixel enable, H/V counters, syncs, H256*.
// Optional macro TANKB_COMPSYNC_EN adds the n_comp_sync output.
module tankb_video_timing
    import tankb_timing_pkg::*;
#(
    parameter logic [8:0]  H_LOAD = H_LOAD_DEF,
    parameter logic [8:0]  V_LOAD = V_LOAD_DEF,
    parameter int unsigned DIV    = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic       m6hz,
    output logic       pix_ce,
    output logic [8:0] h_cnt,
    output logic       h256,
    output logic       h256_star,
    output logic       n_h256_star,
    output logic       n_hsync,
    output logic [8:0] v_cnt,
    output logic       n_vsync,
    output logic       phi,
    output logic       nh4_nh8
`ifdef TANKB_COMPSYNC_EN
    ,
    output logic       n_comp_sync
`endif
);

    // The divider is a fixed three-state ring; other ratios have no implementation.
    if (DIV != 3) begin : g_div_fixed_at_3
    end

    div_state_t div_state, div_next;

    logic       h1, v1;
    logic [3:0] h_lo, h_hi, v_lo, v_hi;
    logic       h_lo_rco, h_hi_rco, v_lo_rco, v_hi_rco;
    logic       h16_rise, h8_rise, v_adv;
    logic       hsync_q;

    // Divider state register
    always_ff @(posedge clk) begin
        if (reset) div_state <= DIV_S0;
        else       div_state <= div_next;
    end

    // Divider next-state ring
    always_comb begin
        div_next = DIV_S0;
        unique case (div_state)
            DIV_S0:  div_next = DIV_S1;
            DIV_S1:  div_next = DIV_S2;
            DIV_S2:  div_next = DIV_S0;
            default: div_next = DIV_S0;
        endcase
    end

    assign pix_ce = (div_state == DIV_S2);
    assign m6hz   = ~div_state[0];

    // H1 toggle; the 161 chain reaches terminal count exactly at h_cnt == 511
    always_ff @(posedge clk) begin
        if (reset)       h1 <= 1'b0;
        else if (pix_ce) h1 <= h_hi_rco ? H_LOAD[0] : ~h1;
    end

    ttl161_cnt u_h_lo (
        .clk(clk), .clr(reset), .ce(pix_ce), .load(h_hi_rco),
        .enp(1'b1), .ent(h1), .d(H_LOAD[4:1]), .q(h_lo), .rco(h_lo_rco)
    );

    ttl161_cnt u_h_hi (
        .clk(clk), .clr(reset), .ce(pix_ce), .load(h_hi_rco),
        .enp(1'b1), .ent(h_lo_rco), .d(H_LOAD[8:5]), .q(h_hi), .rco(h_hi_rco)
    );

    assign h_cnt = {h_hi, h_lo, h1};

    assign h16_rise = pix_ce & (h_cnt[4:0] == 5'd15);
    assign h8_rise  = pix_ce & (h_cnt[3:0] == 4'd7);
    assign v_adv    = pix_ce & (h_cnt == 9'd207);

    // HSYNC flop: samples ~H64 & H32 on H16 rise, held clear while H256 is low
    always_ff @(posedge clk) begin
        if (reset)         hsync_q <= 1'b0;
        else if (h_cnt[8]) hsync_q <= 1'b0;
        else if (h16_rise) hsync_q <= ~h_cnt[6] & h_cnt[5];
    end

    assign n_hsync = ~hsync_q;

    // V1 toggle; V advances on the h 207->208 edge where n_hsync returns high
    always_ff @(posedge clk) begin
        if (reset)      v1 <= 1'b0;
        else if (v_adv) v1 <= v_hi_rco ? V_LOAD[0] : ~v1;
    end

    ttl161_cnt u_v_lo (
        .clk(clk), .clr(reset), .ce(v_adv), .load(v_hi_rco),
        .enp(1'b1), .ent(v1), .d(V_LOAD[4:1]), .q(v_lo), .rco(v_lo_rco)
    );

    ttl161_cnt u_v_hi (
        .clk(clk), .clr(reset), .ce(v_adv), .load(v_hi_rco),
        .enp(1'b1), .ent(v_lo_rco), .d(V_LOAD[8:5]), .q(v_hi), .rco(v_hi_rco)
    );

    assign v_cnt   = {v_hi, v_lo, v1};
    assign n_vsync = v_cnt[8];

    // H256* flop: captures pre-edge H256 on each H8 rise
    always_ff @(posedge clk) begin
        if (reset)        h256_star <= 1'b0;
        else if (h8_rise) h256_star <= ~h_cnt[8];
    end

    assign h256        = ~h_cnt[8];
    assign n_h256_star = ~h256_star;
    assign phi         = h_cnt[2];
    assign nh4_nh8     = ~h_cnt[2] & ~h_cnt[3];

`ifdef TANKB_COMPSYNC_EN
    assign n_comp_sync = n_hsync & n_vsync;
`endif

endmodule

// File: tb/tb_tankb_video_timing.sv
// Directed self-checking bench for tankb_video_timing.
module tb_tankb_video_timing;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m6hz, pix_ce, h256, h256_star, n_h256_star, n_hsync, n_vsync, phi, nh4_nh8;
    logic [8:0] h_cnt, v_cnt;
`ifdef TANKB_COMPSYNC_EN
    logic       n_comp_sync;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned el, tot;
    logic [8:0]  v_force;

    always #5 clk = ~clk;

    tankb_video_timing #(.H_LOAD(9'd128), .V_LOAD(9'd248), .DIV(3)) dut (
        .clk(clk), .reset(reset), .m6hz(m6hz), .pix_ce(pix_ce), .h_cnt(h_cnt),
        .h256(h256), .h256_star(h256_star), .n_h256_star(n_h256_star),
        .n_hsync(n_hsync), .v_cnt(v_cnt), .n_vsync(n_vsync), .phi(phi), .nh4_nh8(nh4_nh8)
`ifdef TANKB_COMPSYNC_EN
        , .n_comp_sync(n_comp_sync)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tick until h_cnt first equals target; returns clocks elapsed.
    task automatic wait_enter(input logic [8:0] target, output int unsigned n);
        n = 0;
        do begin
            tick();
            n++;
        end while (h_cnt !== target && n < 3000);
        if (h_cnt !== target) begin
            checks++;
            errors++;
            $error("FAIL timeout_h%0d: observed h_cnt %0d expected %0d", target, h_cnt, target);
        end
    endtask

    // Preload the vertical counter state directly (mid-cycle, away from edges).
    task automatic set_v(input logic [8:0] val);
        v_force = val;
        force dut.v1       = v_force[0];
        force dut.u_v_lo.q = v_force[4:1];
        force dut.u_v_hi.q = v_force[8:5];
        #1;
        release dut.v1;
        release dut.u_v_lo.q;
        release dut.u_v_hi.q;
    endtask

    initial begin
        // Reset state
        repeat (4) tick();
        check("rst_h", h_cnt, 0);
        check("rst_v", v_cnt, 0);
        check("rst_nhsync", n_hsync, 1);
        check("rst_nvsync", n_vsync, 0);
        check("rst_m6hz", m6hz, 1);
        check("rst_pixce", pix_ce, 0);
        check("rst_h256", h256, 1);
        check("rst_star", h256_star, 0);
        reset = 1'b0;

        // Divider start-up: pix_ce in clk 2, first h advance at clk 3
        tick();
        check("clk1_pixce", pix_ce, 0);
        check("clk1_m6hz", m6hz, 1);
        tick();
        check("clk2_pixce", pix_ce, 1);
        check("clk2_m6hz", m6hz, 0);
        check("clk2_h", h_cnt, 0);
        tick();
        check("clk3_h", h_cnt, 1);
        check("clk3_pixce", pix_ce, 0);
        tick();
        tick();
        check("clk5_pixce", pix_ce, 1);
        tick();
        check("clk6_h", h_cnt, 2);

        // Wrap 511 -> 128
        wait_enter(9'd511, el);
        wait_enter(9'd128, el);
        check("wrap_clks", el, 3);
        check("wrap_v", v_cnt, 1);
        check("wrap_star", h256_star, 0);
        check("h128_nh4nh8", nh4_nh8, 1);
        check("h128_phi", phi, 0);

        // One full steady-state line
        tot = 0;
        wait_enter(9'd132, el); tot += el;
        check("h132_phi", phi, 1);
        wait_enter(9'd135, el); tot += el;
        check("h135_star", h256_star, 0);
        wait_enter(9'd136, el); tot += el;
        check("h136_star", h256_star, 1);
        check("h136_nstar", n_h256_star, 0);
        wait_enter(9'd175, el); tot += el;
        check("h175_nhsync", n_hsync, 1);
        wait_enter(9'd176, el); tot += el;
        check("h176_nhsync", n_hsync, 0);
        wait_enter(9'd207, el); tot += el;
        check("h207_nhsync", n_hsync, 0);
        check("h207_v", v_cnt, 1);
        wait_enter(9'd208, el); tot += el;
        check("h208_nhsync", n_hsync, 1);
        check("h208_v", v_cnt, 2);
        wait_enter(9'd263, el); tot += el;
        check("h263_star", h256_star, 1);
        wait_enter(9'd264, el); tot += el;
        check("h264_star", h256_star, 0);
        check("h264_h256", h256, 0);
        wait_enter(9'd128, el); tot += el;
        check("line_clks", tot, 1152);

        // HSYNC low width
        wait_enter(9'd176, el);
        tot = 0;
        wait_enter(9'd208, el); tot += el;
        check("hsync_low_clks", tot, 96);
        wait_enter(9'd128, el);

        // Vertical reload 511 -> 248
        set_v(9'd511);
        wait_enter(9'd207, el);
        check("v511_v", v_cnt, 511);
        check("v511_nvsync", n_vsync, 1);
        wait_enter(9'd208, el);
        check("vload_v", v_cnt, 248);
        check("vload_nvsync", n_vsync, 0);
`ifdef TANKB_COMPSYNC_EN
        check("vload_comp", n_comp_sync, 0);
`endif
        wait_enter(9'd128, el);

        // Leaving vsync 255 -> 256
        set_v(9'd255);
        wait_enter(9'd207, el);
        check("v255_nvsync", n_vsync, 0);
        wait_enter(9'd208, el);
        check("v256_v", v_cnt, 256);
        check("v256_nvsync", n_vsync, 1);
`ifdef TANKB_COMPSYNC_EN
        check("v256_comp", n_comp_sync, 1);
`endif
        wait_enter(9'd128, el);

        // Carry across counter cells 31 -> 32
        set_v(9'd31);
        wait_enter(9'd208, el);
        check("v32_v", v_cnt, 32);

        // Reset mid-line at h=300, v=400
        wait_enter(9'd210, el);
        set_v(9'd400);
        wait_enter(9'd300, el);
        check("mid_v", v_cnt, 400);
        check("mid_h256", h256, 0);
        reset = 1'b1;
        tick();
        check("mrst_h", h_cnt, 0);
        check("mrst_v", v_cnt, 0);
        check("mrst_nhsync", n_hsync, 1);
        check("mrst_nvsync", n_vsync, 0);
        check("mrst_star", h256_star, 0);
        check("mrst_pixce", pix_ce, 0);
        check("mrst_m6hz", m6hz, 1);
        reset = 1'b0;
        tick();
        check("mrel1_pixce", pix_ce, 0);
        tick();
        check("mrel2_pixce", pix_ce, 1);
        tick();
        check("mrel3_h", h_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
